// File: rtl/tile_lsu_ipa.sv
// tile_lsu_ipa: load/store unit for the IPA PE tile.
//
// Holds one memory request until it is granted, tracks up to DEPTH
// outstanding loads in a destination-tag FIFO, and drives a registered
// writeback strobe into the register file. Stall_Out feeds the tile's
// global stall network.
//
// Ports:
//   Clk, Reset (async, active-low)
//   Exec_En_I                       tile executing; gates new operations
//   Op_*_I / Op_Ready_O             operation handshake from PE controller
//   Load_Store_{Req,Wen,Addr}_O,
//   Store_Data_O, Load_Store_Grant_I  TCDM request channel
//   Data_Req_Valid_I, Load_Data_I   TCDM load response
//   Wb_{Valid,Data,Dst}_O           register-file writeback
//   Stall_Out, Busy_O, Err_O        status (Err_O sticky)
//   Active_Cnt_O, Stall_Cnt_O       performance counters
//
// Build option: define TILE_LSU_PERF_CNT_EN to implement the performance
// counters; otherwise both counter ports are tied to zero.
module tile_lsu_ipa #(
   parameter int unsigned DWIDTH    = 32,
   parameter int unsigned AWIDTH    = 32,
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned TAG_W     = 3,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Exec_En_I,
   input  logic                 Op_Valid_I,
   input  logic                 Op_Store_I,
   input  logic [AWIDTH-1:0]    Op_Addr_I,
   input  logic [DWIDTH-1:0]    Op_Data_I,
   input  logic [TAG_W-1:0]     Op_Dst_I,
   output logic                 Op_Ready_O,
   output logic                 Load_Store_Req_O,
   output logic                 Load_Store_Wen_O,
   output logic [AWIDTH-1:0]    Load_Store_Addr_O,
   output logic [DWIDTH-1:0]    Store_Data_O,
   input  logic                 Load_Store_Grant_I,
   input  logic                 Data_Req_Valid_I,
   input  logic [DWIDTH-1:0]    Load_Data_I,
   output logic                 Wb_Valid_O,
   output logic [DWIDTH-1:0]    Wb_Data_O,
   output logic [TAG_W-1:0]     Wb_Dst_O,
   output logic                 Stall_Out,
   output logic                 Busy_O,
   output logic                 Err_O,
   output logic [CNT_WIDTH-1:0] Active_Cnt_O,
   output logic [CNT_WIDTH-1:0] Stall_Cnt_O
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [OCC_W-1:0] occ_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [TAG_W-1:0] tag_mem [DEPTH];

   logic accept_c;
   logic push_c;
   logic pop_c;
   logic fifo_nempty_c;

   // Pointer increment with wrap at DEPTH.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   // Handshake and FIFO control; occupancy is sampled, never bypassed from a
   // same-cycle response.
   always_comb begin
      fifo_nempty_c = (occ_q != '0);
      Op_Ready_O    = Exec_En_I
                    & (~Load_Store_Req_O | Load_Store_Grant_I)
                    & (Op_Store_I | (occ_q < OCC_W'(DEPTH)));
      accept_c      = Op_Valid_I & Op_Ready_O;
      push_c        = accept_c & ~Op_Store_I;
      pop_c         = Data_Req_Valid_I & fifo_nempty_c;
      Stall_Out     = Op_Valid_I & ~Op_Ready_O;
      Busy_O        = Load_Store_Req_O | fifo_nempty_c;
   end

   // Held request register: stable until granted, reloaded back-to-back.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Load_Store_Req_O  <= 1'b0;
         Load_Store_Wen_O  <= 1'b0;
         Load_Store_Addr_O <= '0;
         Store_Data_O      <= '0;
      end else if (accept_c) begin
         Load_Store_Req_O  <= 1'b1;
         Load_Store_Wen_O  <= Op_Store_I;
         Load_Store_Addr_O <= AWIDTH'(Op_Addr_I << 2);
         Store_Data_O      <= Op_Data_I;
      end else if (Load_Store_Grant_I) begin
         Load_Store_Req_O  <= 1'b0;
      end
   end

   // Destination-tag FIFO and outstanding-load count.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         occ_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            tag_mem[i] <= '0;
         end
      end else begin
         if (push_c) begin
            tag_mem[wr_ptr_q] <= Op_Dst_I;
            wr_ptr_q          <= ptr_inc(wr_ptr_q);
         end
         if (pop_c) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push_c, pop_c})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Registered writeback and sticky error for responses with nothing pending.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Wb_Valid_O <= 1'b0;
         Wb_Data_O  <= '0;
         Wb_Dst_O   <= '0;
         Err_O      <= 1'b0;
      end else begin
         Wb_Valid_O <= pop_c;
         if (pop_c) begin
            Wb_Data_O <= Load_Data_I;
            Wb_Dst_O  <= tag_mem[rd_ptr_q];
         end
         if (Data_Req_Valid_I && !fifo_nempty_c) begin
            Err_O <= 1'b1;
         end
      end
   end

`ifdef TILE_LSU_PERF_CNT_EN
   // Saturating activity/stall counters, cleared only by reset.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Active_Cnt_O <= '0;
         Stall_Cnt_O  <= '0;
      end else begin
         if (Exec_En_I && !Stall_Out && (Active_Cnt_O != '1)) begin
            Active_Cnt_O <= Active_Cnt_O + CNT_WIDTH'(1);
         end
         if (Exec_En_I && Stall_Out && (Stall_Cnt_O != '1)) begin
            Stall_Cnt_O <= Stall_Cnt_O + CNT_WIDTH'(1);
         end
      end
   end
`else
   // Counters removed; ports kept so the tile netlist is unchanged.
   assign Active_Cnt_O = '0;
   assign Stall_Cnt_O  = '0;
`endif

endmodule
